dbus_arbiter: RTL and testbench

- Shares the single data-side bus between two masters: M0 (CPU memory stage, after byte-enable generation) and M1 (debug/DMA port).
- Decodes the address into DM, Timer0, Timer1 and the interrupt generator (IG).
- Sequences DM wait states and returns a one-cycle ack with read data or an error flag.
- Sits between the CPU/bridge and the slave devices in the top-level system.

---
 rtl/dbus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Data-side bus arbiter: round-robin grant of M0/M1, address decode to DM/TC0/TC1/IG, DM wait sequencing.
// Latency: ack two cycles after the grant cycle (2+DM_WAIT for DM); one idle cycle between transactions.
// Backpressure: masters hold req until the one-cycle ack; no new grant is made until the FSM is back in IDLE.
module dbus_arbiter #(
    parameter int unsigned DM_WAIT = 2,
    parameter logic [31:0] DM_TOP  = 32'h0000_2fff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    output logic        dm_en,
    output logic        tc0_we,
    output logic        tc1_we,
    output logic        ig_we,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] tc0_rdata,
    input  logic [31:0] tc1_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [2:0] {T_DM, T_TC0, T_TC1, T_IG, T_MISS} tgt_t;

    localparam logic [3:0] WAIT_INIT = (DM_WAIT > 0) ? 4'(DM_WAIT - 1) : 4'd0;

    state_t      state_q, state_d;
    tgt_t        tgt_q, tgt_d, in_tgt;
    logic        last_grant_q, last_grant_d;   // 1 = M1 was granted last
    logic        gnt_q, gnt_d;                 // 1 = M1 owns the current transaction
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic [3:0]  s_byteen_q, s_byteen_d;
    logic        dm_en_q, dm_en_d, tc0_we_q, tc0_we_d, tc1_we_q, tc1_we_d, ig_we_q, ig_we_d;
    logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d, m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic        pick_m1, in_write, in_err, is_tc, resp_go;
    logic [31:0] in_addr, in_wdata, resp_rdata;
    logic [3:0]  in_byteen;

    // Arbitration and decode of the request about to be granted (same value that gets latched)
    always_comb begin
        pick_m1   = m1_req && (!m0_req || !last_grant_q);
        in_addr   = pick_m1 ? m1_addr   : m0_addr;
        in_byteen = pick_m1 ? m1_byteen : m0_byteen;
        in_wdata  = pick_m1 ? m1_wdata  : m0_wdata;
        in_write  = (in_byteen != 4'b0000);
        in_tgt    = T_MISS;
        if (in_addr <= DM_TOP)                                 in_tgt = T_DM;
        else if (in_addr >= 32'h7f00 && in_addr <= 32'h7f0b)   in_tgt = T_TC0;
        else if (in_addr >= 32'h7f10 && in_addr <= 32'h7f1b)   in_tgt = T_TC1;
        else if (in_addr >= 32'h7f20 && in_addr <= 32'h7f23)   in_tgt = T_IG;
        is_tc  = (in_tgt == T_TC0) || (in_tgt == T_TC1);
        // Timers only take aligned full-word accesses, and the count register (offset 8) is read-only
        in_err = (in_tgt == T_MISS) ||
                 (is_tc && ((in_write && in_byteen != 4'b1111) ||
                            (in_addr[1:0] != 2'b00) ||
                            (in_write && in_addr[3:0] == 4'h8)));
    end

    // Read data returned with the ack; rejected accesses and IG return zero
    always_comb begin
        resp_rdata = 32'h0;
        if (!err_q) begin
            case (tgt_q)
                T_DM:    resp_rdata = dm_rdata;
                T_TC0:   resp_rdata = tc0_rdata;
                T_TC1:   resp_rdata = tc1_rdata;
                default: resp_rdata = 32'h0;
            endcase
        end
    end

    // FSM next state, latch of the granted request, one-cycle strobes and ack
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_byteen_d   = s_byteen_q;
        dm_en_d      = 1'b0;
        tc0_we_d     = 1'b0;
        tc1_we_d     = 1'b0;
        ig_we_d      = 1'b0;
        m0_ack_d     = 1'b0;
        m0_err_d     = 1'b0;
        m0_rdata_d   = 32'h0;
        m1_ack_d     = 1'b0;
        m1_err_d     = 1'b0;
        m1_rdata_d   = 32'h0;
        resp_go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = S_ISSUE;
                    gnt_d        = pick_m1;
                    last_grant_d = pick_m1;
                    s_addr_d     = in_addr;
                    s_wdata_d    = in_wdata;
                    s_byteen_d   = in_byteen;
                    tgt_d        = in_tgt;
                    err_d        = in_err;
                    // Strobes are registered here so they are visible exactly during ISSUE
                    dm_en_d      = (in_tgt == T_DM);
                    tc0_we_d     = (in_tgt == T_TC0) && in_write && !in_err;
                    tc1_we_d     = (in_tgt == T_TC1) && in_write && !in_err;
                    ig_we_d      = (in_tgt == T_IG) && in_write;
                end
            end
            S_ISSUE: begin
                if (tgt_q == T_DM && DM_WAIT > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    resp_go = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) resp_go = 1'b1;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (resp_go) begin
            state_d = S_RESP;
            if (gnt_q) begin
                m1_ack_d   = 1'b1;
                m1_err_d   = err_q;
                m1_rdata_d = resp_rdata;
            end else begin
                m0_ack_d   = 1'b1;
                m0_err_d   = err_q;
                m0_rdata_d = resp_rdata;
            end
        end
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tgt_q        <= T_MISS;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 4'd0;
            s_addr_q     <= 32'h0;
            s_wdata_q    <= 32'h0;
            s_byteen_q   <= 4'h0;
            dm_en_q      <= 1'b0;
            tc0_we_q     <= 1'b0;
            tc1_we_q     <= 1'b0;
            ig_we_q      <= 1'b0;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rdata_q   <= 32'h0;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_byteen_q   <= s_byteen_d;
            dm_en_q      <= dm_en_d;
            tc0_we_q     <= tc0_we_d;
            tc1_we_q     <= tc1_we_d;
            ig_we_q      <= ig_we_d;
            m0_ack_q     <= m0_ack_d;
            m0_err_q     <= m0_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_ack_q     <= m1_ack_d;
            m1_err_q     <= m1_err_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_byteen = s_byteen_q;
    assign dm_en    = dm_en_q;
    assign tc0_we   = tc0_we_q;
    assign tc1_we   = tc1_we_q;
    assign ig_we    = ig_we_q;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus randomized request pairs against a transaction-level model.
// Latency: outputs sampled on the falling edge; ack cycle counted from the grant edge.
// Backpressure: masters hold req until their ack (optionally dropping it after the grant).
module tb_dbus_arbiter;
    localparam int unsigned DM_WAIT = 2;
    localparam logic [31:0] DM_TOP  = 32'h0000_2fff;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_byteen, m1_byteen, s_byteen;
    logic [31:0] s_addr, s_wdata, dm_rdata, tc0_rdata, tc1_rdata;
    logic        dm_en, tc0_we, tc1_we, ig_we;

    dbus_arbiter #(.DM_WAIT(DM_WAIT), .DM_TOP(DM_TOP)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
        .dm_en(dm_en), .tc0_we(tc0_we), .tc1_we(tc1_we), .ig_we(ig_we),
        .dm_rdata(dm_rdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit lg;   // model: 1 when M1 was the last master granted

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Model: 0 DM, 1 TC0, 2 TC1, 3 IG, 4 miss
    function automatic int m_tgt(input logic [31:0] a);
        if (a <= DM_TOP) return 0;
        if (a >= 32'h7f00 && a <= 32'h7f0b) return 1;
        if (a >= 32'h7f10 && a <= 32'h7f1b) return 2;
        if (a >= 32'h7f20 && a <= 32'h7f23) return 3;
        return 4;
    endfunction

    function automatic logic m_err(input logic [31:0] a, input logic [3:0] be);
        int t;
        logic [31:0] off;
        t = m_tgt(a);
        if (t == 4) return 1'b1;
        if (t == 1 || t == 2) begin
            off = a - ((t == 1) ? 32'h7f00 : 32'h7f10);
            if (be != 4'h0 && be != 4'hf) return 1'b1;
            if (a % 4 != 0) return 1'b1;
            if (be != 4'h0 && off == 32'h8) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected strobe in ISSUE as {dm_en, tc0_we, tc1_we, ig_we}
    function automatic logic [3:0] m_strobe(input logic [31:0] a, input logic [3:0] be);
        int t;
        t = m_tgt(a);
        if (m_err(a, be)) return 4'b0000;
        if (t == 0) return 4'b1000;
        if (be == 4'h0) return 4'b0000;
        if (t == 1) return 4'b0100;
        if (t == 2) return 4'b0010;
        return 4'b0001;
    endfunction

    function automatic int m_lat(input logic [31:0] a);
        return 2 + ((m_tgt(a) == 0) ? int'(DM_WAIT) : 0);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic [3:0] be);
        int t;
        t = m_tgt(a);
        if (m_err(a, be)) return 32'h0;
        if (t == 0) return dm_rdata;
        if (t == 1) return tc0_rdata;
        if (t == 2) return tc1_rdata;
        return 32'h0;
    endfunction

    function automatic logic [31:0] gen_addr();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, DM_TOP));
            1:       return DM_TOP - 32'd2 + 32'($urandom_range(0, 4));
            2:       return 32'h7f00 + 32'($urandom_range(0, 15));
            3:       return 32'h7f10 + 32'($urandom_range(0, 15));
            4:       return 32'h7f1c + 32'($urandom_range(0, 11));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [3:0] gen_be();
        case ($urandom_range(0, 4))
            0:       return 4'h0;
            1:       return 4'hf;
            2:       return 4'h3;
            3:       return 4'h0;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Present one or two requests in the same cycle and check both transactions end to end
    task automatic run_pair(input string tag,
                            input bit r0, input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                            input bit r1, input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                            input bit drop_win);
        logic [31:0] ad [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        int          order [2];
        int          ack_at [2];
        int          ack_cnt [2];
        int          iss_at [2];
        int          exp_ack [2];
        logic        err_got [2];
        logic [31:0] rd_got [2];
        logic [3:0]  stb [0:99];
        logic [31:0] sa [0:99];
        logic [31:0] sw [0:99];
        logic [3:0]  sb [0:99];
        int n_tx, last_i, n_stb_got, n_stb_exp, m;
        ad[0] = a0; be[0] = b0; wd[0] = w0;
        ad[1] = a1; be[1] = b1; wd[1] = w1;
        order[0] = 0; order[1] = 0; n_tx = 0;
        if (r0 && r1) begin order[0] = lg ? 0 : 1; order[1] = 1 - order[0]; n_tx = 2; end
        else if (r0)  begin order[0] = 0; n_tx = 1; end
        else if (r1)  begin order[0] = 1; n_tx = 1; end
        if (n_tx == 0) return;
        for (int k = 0; k < 2; k++) begin
            ack_at[k] = -1; ack_cnt[k] = 0; iss_at[k] = 0; exp_ack[k] = 0;
            err_got[k] = 1'b0; rd_got[k] = 32'h0;
        end
        iss_at[order[0]]  = 1;
        exp_ack[order[0]] = m_lat(ad[order[0]]);
        if (n_tx == 2) begin
            iss_at[order[1]]  = exp_ack[order[0]] + 2;
            exp_ack[order[1]] = exp_ack[order[0]] + 1 + m_lat(ad[order[1]]);
        end
        last_i = exp_ack[order[n_tx-1]] + 3;
        n_stb_got = 0; n_stb_exp = 0;

        @(negedge clk);
        m0_req = r0; m0_addr = a0; m0_byteen = b0; m0_wdata = w0;
        m1_req = r1; m1_addr = a1; m1_byteen = b1; m1_wdata = w1;
        for (int i = 1; i <= last_i; i++) begin
            @(negedge clk);
            stb[i] = {dm_en, tc0_we, tc1_we, ig_we};
            sa[i] = s_addr; sw[i] = s_wdata; sb[i] = s_byteen;
            if (stb[i] != 4'h0) n_stb_got++;
            if (m0_ack) begin
                ack_cnt[0]++;
                if (ack_at[0] < 0) begin ack_at[0] = i; err_got[0] = m0_err; rd_got[0] = m0_rdata; end
            end else chk({tag, ":m0_idle_rdata"}, m0_rdata, 32'h0);
            if (m1_ack) begin
                ack_cnt[1]++;
                if (ack_at[1] < 0) begin ack_at[1] = i; err_got[1] = m1_err; rd_got[1] = m1_rdata; end
            end else chk({tag, ":m1_idle_rdata"}, m1_rdata, 32'h0);
            if (drop_win && i == 1) begin
                if (order[0] == 0) m0_req = 1'b0; else m1_req = 1'b0;
            end
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;

        for (int k = 0; k < n_tx; k++) begin
            m = order[k];
            chk({tag, m ? ":m1_ack_cycle" : ":m0_ack_cycle"}, ack_at[m], exp_ack[m]);
            chk({tag, m ? ":m1_ack_count" : ":m0_ack_count"}, ack_cnt[m], 1);
            chk({tag, m ? ":m1_err" : ":m0_err"}, {31'h0, err_got[m]}, {31'h0, m_err(ad[m], be[m])});
            if (be[m] == 4'h0 || m_err(ad[m], be[m]))
                chk({tag, m ? ":m1_rdata" : ":m0_rdata"}, rd_got[m], m_rdata(ad[m], be[m]));
            chk({tag, m ? ":m1_strobe" : ":m0_strobe"}, {28'h0, stb[iss_at[m]]}, {28'h0, m_strobe(ad[m], be[m])});
            chk({tag, m ? ":m1_s_addr" : ":m0_s_addr"}, sa[iss_at[m]], ad[m]);
            chk({tag, m ? ":m1_s_wdata" : ":m0_s_wdata"}, sw[iss_at[m]], wd[m]);
            chk({tag, m ? ":m1_s_byteen" : ":m0_s_byteen"}, {28'h0, sb[iss_at[m]]}, {28'h0, be[m]});
            if (m_strobe(ad[m], be[m]) != 4'h0) n_stb_exp++;
        end
        chk({tag, ":strobe_cycles"}, n_stb_got, n_stb_exp);
        lg = (order[n_tx-1] == 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ":s_addr"}, s_addr, 32'h0);
        chk({tag, ":s_wdata"}, s_wdata, 32'h0);
        chk({tag, ":s_byteen"}, {28'h0, s_byteen}, 32'h0);
        chk({tag, ":strobes"}, {28'h0, dm_en, tc0_we, tc1_we, ig_we}, 32'h0);
        chk({tag, ":acks_errs"}, {28'h0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
        chk({tag, ":rdata"}, m0_rdata | m1_rdata, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; lg = 1'b1;
        m0_req = 1'b0; m0_addr = 32'h0; m0_byteen = 4'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_addr = 32'h0; m1_byteen = 4'h0; m1_wdata = 32'h0;
        dm_rdata = 32'h0; tc0_rdata = 32'h0; tc1_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: M0, then M1, then M0 again
        dm_rdata = 32'hdead_0001; tc0_rdata = 32'h1111_2222; tc1_rdata = 32'h3333_4444;
        run_pair("tie1", 1, 32'h0000_0040, 4'h0, 32'h0, 1, 32'h0000_7f14, 4'h0, 32'h0, 0);
        run_pair("tie2", 1, 32'h0000_7f00, 4'hf, 32'ha5a5_a5a5, 1, 32'h0000_0080, 4'hf, 32'h5a5a_5a5a, 0);

        // DM write, DM_WAIT cycles of wait
        run_pair("dm_wr", 1, 32'h0000_0010, 4'hf, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0, 0);

        // M1 timer read
        tc0_rdata = 32'h0000_abcd;
        run_pair("tc0_rd", 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_7f04, 4'h0, 32'h0, 0);

        // Rejected accesses, then an IG write, and the DM boundary on both sides
        run_pair("tc_cnt_wr", 1, 32'h0000_7f08, 4'hf, 32'h1, 0, 32'h0, 4'h0, 32'h0, 0);
        run_pair("tc_part_wr", 1, 32'h0000_7f10, 4'h3, 32'h2, 0, 32'h0, 4'h0, 32'h0, 0);
        run_pair("miss", 1, 32'h0000_3000, 4'hf, 32'h3, 0, 32'h0, 4'h0, 32'h0, 0);
        run_pair("tc_misalign", 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_7f01, 4'h0, 32'h0, 0);
        run_pair("ig_wr", 1, 32'h0000_7f20, 4'hf, 32'h0000_0007, 0, 32'h0, 4'h0, 32'h0, 0);
        run_pair("ig_rd", 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_7f20, 4'h0, 32'h0, 0);
        run_pair("dm_top", 1, DM_TOP, 4'h0, 32'h0, 1, DM_TOP + 32'd1, 4'h0, 32'h0, 0);

        // Reset while the DM access is in WAIT: outputs clear at once and no ack follows
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_byteen = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_outputs_zero("rst_wait");
        m0_req = 1'b0;
        @(negedge clk);
        reset = 1'b0; lg = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_wait:no_ack", {31'h0, m0_ack}, 32'h0);
            chk("rst_wait:no_strobe", {28'h0, dm_en, tc0_we, tc1_we, ig_we}, 32'h0);
        end
        run_pair("after_rst", 1, 32'h0000_0200, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0);

        // M0 drops req once granted: the transaction still completes on time
        run_pair("drop", 1, 32'h0000_0300, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1);

        // Randomized request pairs
        for (int n = 0; n < 60; n++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            dm_rdata  = $urandom();
            tc0_rdata = $urandom();
            tc1_rdata = $urandom();
            run_pair("rand", r0, gen_addr(), gen_be(), $urandom(), r1, gen_addr(), gen_be(), $urandom(),
                     ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
